sram_b_stream_ctrl: RTL and testbench

- Initiator-side controller for the 1-write/1-read banked SRAM (sram_b family: 16 address bits, 8 data bits, 1-cycle read latency).
- Converts a valid/ready write stream into port-0 accesses.
- Converts a burst-read command (base address, length) into port-1 accesses, returning data on a valid/ready stream with last-beat tagging.
- Provides backpressure-safe buffering and prevents same-address read/write collisions.
- Sits between accelerator datapath logic and the SRAM instance.

---
 rtl/sram_b_ctrl_pkg.sv | 17 +
 rtl/sram_b_rd_fifo.sv | 68 ++++++
 rtl/sram_b_stream_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sram_b_stream_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_b_ctrl_pkg.sv
// Shared definitions for the sram_b initiator-side stream controller.
// Holds default geometry, the read-engine state encoding and the FIFO depth floor.
package sram_b_ctrl_pkg;

    localparam int unsigned DEF_ABITS     = 16;
    localparam int unsigned DEF_DBITS     = 8;
    localparam int unsigned DEF_LENBITS   = 16;
    // Below this depth the issue credit cannot cover the 2-cycle read pipeline.
    localparam int unsigned MIN_OUT_DEPTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sram_b_rd_fifo.sv
// Synchronous read-return FIFO; push and pop may coincide even when full.
module sram_b_rd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != CW'(DEPTH)) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/sram_b_stream_ctrl.sv
// Stream-to-SRAM initiator: registered write port, burst read engine with
// credit-gated issue, write-wins collision avoidance and a return FIFO.
module sram_b_stream_ctrl
    import sram_b_ctrl_pkg::*;
#(
    parameter int unsigned ABITS     = DEF_ABITS,
    parameter int unsigned DBITS     = DEF_DBITS,
    parameter int unsigned LENBITS   = DEF_LENBITS,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ABITS-1:0]   wr_addr,
    input  logic [DBITS-1:0]   wr_data,
    input  logic [DBITS-1:0]   wr_mask,
    input  logic               rd_cmd_valid,
    output logic               rd_cmd_ready,
    input  logic [ABITS-1:0]   rd_cmd_addr,
    input  logic [LENBITS-1:0] rd_cmd_len,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [DBITS-1:0]   rd_data,
    output logic               rd_last,
    output logic               busy,
    output logic               CE0,
    output logic [ABITS-1:0]   A0,
    output logic [DBITS-1:0]   D0,
    output logic               WE0,
    output logic [DBITS-1:0]   WEM0,
    output logic               CE1,
    output logic [ABITS-1:0]   A1,
    input  logic [DBITS-1:0]   Q1
);

    localparam int unsigned        CW       = $clog2(OUT_DEPTH + 1);
    localparam int unsigned        CSW      = CW + 1;
    localparam logic [ABITS-1:0]   ADDR_ONE = ABITS'(1);
    localparam logic [LENBITS-1:0] LEN_ONE  = LENBITS'(1);

    if (OUT_DEPTH < MIN_OUT_DEPTH) begin : g_depth_check
        $error("sram_b_stream_ctrl: OUT_DEPTH below MIN_OUT_DEPTH");
    end

    rd_state_e          state_q, state_d;
    logic [ABITS-1:0]   ptr_q, ptr_d;
    logic [LENBITS-1:0] rem_q, rem_d;

    logic               ce0_q, ce0_d;
    logic [ABITS-1:0]   a0_q, a0_d;
    logic [DBITS-1:0]   d0_q, d0_d;
    logic [DBITS-1:0]   wem0_q, wem0_d;

    logic               ce1_q, ce1_d;
    logic [ABITS-1:0]   a1_q, a1_d;
    logic               last1_q, last1_d;
    logic               q_pend_q, q_pend_d;
    logic               q_last_q, q_last_d;

    logic               fifo_empty, fifo_full;
    logic [CW-1:0]      fifo_count;
    logic [DBITS:0]     fifo_rdata;

    logic [CSW-1:0]     credit_sum;
    logic               credit_ok, collide;

    assign wr_ready = ~RST;

    always_comb begin
        ce0_d  = wr_valid & wr_ready;
        a0_d   = a0_q;
        d0_d   = d0_q;
        wem0_d = wem0_q;
        if (wr_valid) begin
            a0_d   = wr_addr;
            d0_d   = wr_data;
            wem0_d = wr_mask;
        end
    end

    // In-flight reads (CE1 stage, Q1 stage) each own a FIFO slot; pops give no credit.
    always_comb begin
        credit_sum = CSW'(ce1_q) + CSW'(q_pend_q) + CSW'(fifo_count);
        credit_ok  = (credit_sum < CSW'(OUT_DEPTH)) & ~fifo_full;
        collide    = wr_valid & (wr_addr == ptr_q);
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rem_d        = rem_q;
        ce1_d        = 1'b0;
        a1_d         = a1_q;
        last1_d      = 1'b0;
        rd_cmd_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rd_cmd_ready = ~RST;
                if (rd_cmd_valid & ~RST) begin
                    ptr_d   = rd_cmd_addr;
                    rem_d   = rd_cmd_len;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A same-address write this cycle wins; the read retries next cycle.
                if (credit_ok & ~collide) begin
                    ce1_d   = 1'b1;
                    a1_d    = ptr_q;
                    last1_d = (rem_q == '0);
                    ptr_d   = ptr_q + ADDR_ONE;
                    rem_d   = rem_q - LEN_ONE;
                    if (rem_q == '0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (rd_valid & rd_ready & rd_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        q_pend_d = ce1_q;
        q_last_d = last1_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            ce0_q    <= 1'b0;
            a0_q     <= '0;
            d0_q     <= '0;
            wem0_q   <= '0;
            ce1_q    <= 1'b0;
            a1_q     <= '0;
            last1_q  <= 1'b0;
            q_pend_q <= 1'b0;
            q_last_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            ce0_q    <= ce0_d;
            a0_q     <= a0_d;
            d0_q     <= d0_d;
            wem0_q   <= wem0_d;
            ce1_q    <= ce1_d;
            a1_q     <= a1_d;
            last1_q  <= last1_d;
            q_pend_q <= q_pend_d;
            q_last_q <= q_last_d;
        end
    end

    sram_b_rd_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (DBITS + 1)
    ) u_rd_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (q_pend_q),
        .wdata ({q_last_q, Q1}),
        .pop   (rd_ready),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign rd_valid = ~fifo_empty;
    assign rd_data  = fifo_empty ? '0 : fifo_rdata[DBITS-1:0];
    assign rd_last  = ~fifo_empty & fifo_rdata[DBITS];
    assign busy     = (state_q != ST_IDLE) | ce0_q;

    assign CE0  = ce0_q;
    assign WE0  = ce0_q;
    assign A0   = a0_q;
    assign D0   = d0_q;
    assign WEM0 = wem0_q;
    assign CE1  = ce1_q;
    assign A1   = a1_q;

endmodule

// File: tb/tb_sram_b_stream_ctrl.sv
// Scoreboard bench for sram_b_stream_ctrl with a behavioural 1W/1R SRAM attached.
module tb_sram_b_stream_ctrl;

    localparam int unsigned DEPTH = 4;

    logic        CLK, RST;
    logic        wr_valid, wr_ready;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data, wr_mask;
    logic        rd_cmd_valid, rd_cmd_ready;
    logic [15:0] rd_cmd_addr, rd_cmd_len;
    logic        rd_valid, rd_ready, rd_last, busy;
    logic [7:0]  rd_data;
    logic        CE0, WE0, CE1;
    logic [15:0] A0, A1;
    logic [7:0]  D0, WEM0, Q1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [8:0]  exp_q[$];
    logic [15:0] a1_log[$];
    logic [7:0]  sram    [65536];
    logic [7:0]  ref_mem [65536];
    int          issued, popped, last_pop_cyc;
    int          cyc = 0;
    logic        stall_pending, b2b_en, b2b_seen, tog_en;
    logic [8:0]  held, exp_beat;

    sram_b_stream_ctrl #(
        .ABITS(16), .DBITS(8), .LENBITS(16), .OUT_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .busy(busy),
        .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
        .CE1(CE1), .A1(A1), .Q1(Q1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (CE0 && WE0) sram[A0] <= (sram[A0] & ~WEM0) | (D0 & WEM0);
        if (CE1) Q1 <= sram[A1];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pop, stall stability, credit and collision invariants.
    always @(negedge CLK) begin
        if (RST) begin
            issued = 0;
            popped = 0;
            stall_pending = 1'b0;
            b2b_seen = 1'b0;
        end else begin
            if (CE1) begin
                a1_log.push_back(A1);
                issued++;
                check_eq("rd_wr_collision", 32'(CE0 && WE0 && (A0 == A1)), 0);
                check_eq("outstanding_le_depth", 32'((issued - popped) <= int'(DEPTH)), 1);
            end
            if (stall_pending) begin
                check_eq("stall_valid_held", 32'(rd_valid), 1);
                check_eq("stall_beat_stable", 32'({rd_last, rd_data}), 32'(held));
            end
            stall_pending = rd_valid && !rd_ready;
            held = {rd_last, rd_data};
            if (rd_valid && rd_ready) begin
                check_eq("beat_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    check_eq("rd_data", 32'(rd_data), 32'(exp_beat[7:0]));
                    check_eq("rd_last", 32'(rd_last), 32'(exp_beat[8]));
                end
                popped++;
                if (b2b_en) begin
                    if (b2b_seen) check_eq("b2b_gap", 32'(cyc - last_pop_cyc), 1);
                    b2b_seen = 1'b1;
                    last_pop_cyc = cyc;
                end else begin
                    b2b_seen = 1'b0;
                end
            end
        end
    end

    task automatic drive_write(input logic [15:0] a, input logic [7:0] d, input logic [7:0] m);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_mask  = m;
        ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
        @(negedge CLK);
        check_eq("wr_ready", 32'(wr_ready), 1);
        @(posedge CLK);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic write_word(input logic [15:0] a, input logic [7:0] d, input logic [7:0] m);
        @(posedge CLK);
        #1;
        drive_write(a, d, m);
    endtask

    task automatic push_burst(input logic [15:0] base, input int unsigned len);
        logic [15:0] a;
        for (int unsigned i = 0; i <= len; i++) begin
            a = base + 16'(i);
            exp_q.push_back({(i == len), ref_mem[a]});
        end
    endtask

    // Returns at handshake edge + 1.
    task automatic send_cmd(input logic [15:0] a, input logic [15:0] len);
        bit ok = 1'b0;
        @(posedge CLK);
        #1;
        rd_cmd_addr  = a;
        rd_cmd_len   = len;
        rd_cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (rd_cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("cmd_accept", 32'(ok), 1);
        @(posedge CLK);
        #1;
        rd_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(ok), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  pat;
        logic [15:0] a;
        int          k;
        RST = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_cmd_valid = 1'b0; rd_cmd_addr = '0; rd_cmd_len = '0;
        rd_ready = 1'b1;
        b2b_en = 1'b0;
        tog_en = 1'b0;
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_wr_ready", 32'(wr_ready), 0);
        check_eq("rst_cmd_ready", 32'(rd_cmd_ready), 0);
        check_eq("rst_outs", 32'({CE0, WE0, CE1, rd_valid, rd_last, busy}), 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("idle_wr_ready", 32'(wr_ready), 1);
        check_eq("idle_cmd_ready", 32'(rd_cmd_ready), 1);

        // Sequential burst, full throughput, latency
        for (int i = 0; i < 8; i++) write_word(16'(i), 8'(8'h11 + i), 8'hFF);
        push_burst(16'h0000, 7);
        b2b_en = 1'b1;
        send_cmd(16'h0000, 16'd7);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check_eq("first_data_early", 32'(rd_valid), 0);
        @(negedge CLK);
        check_eq("first_data_latency", 32'(rd_valid), 1);
        wait_done("burst8_done");
        b2b_en = 1'b0;

        // Same burst with rd_ready pattern 1-0-0-1
        pat = 4'b1001;
        k = 0;
        tog_en = 1'b1;
        fork
            while (tog_en) begin
                @(posedge CLK);
                #1;
                rd_ready = pat[k];
                k = (k + 1) % 4;
            end
        join_none
        push_burst(16'h0000, 7);
        send_cmd(16'h0000, 16'd7);
        wait_done("stall_burst_done");
        tog_en = 1'b0;
        @(posedge CLK);
        #2;
        rd_ready = 1'b1;

        // Collision: write to the burst base in the first issue cycle
        for (int i = 0; i < 4; i++) write_word(16'(16'h0010 + i), 8'(8'h50 + i), 8'hFF);
        send_cmd(16'h0010, 16'd3);
        drive_write(16'h0010, 8'hA5, 8'hFF);
        @(negedge CLK);
        check_eq("coll_ce1_withheld", 32'(CE1), 0);
        check_eq("coll_ce0_active", 32'(CE0), 1);
        push_burst(16'h0010, 3);
        wait_done("coll_burst_done");

        // Address wrap
        write_word(16'hFFFE, 8'hC0, 8'hFF);
        write_word(16'hFFFF, 8'hC1, 8'hFF);
        write_word(16'h0000, 8'hC2, 8'hFF);
        write_word(16'h0001, 8'hC3, 8'hFF);
        a1_log.delete();
        push_burst(16'hFFFE, 3);
        send_cmd(16'hFFFE, 16'd3);
        wait_done("wrap_burst_done");
        check_eq("wrap_a1_count", 32'(a1_log.size()), 4);
        a = 16'hFFFE;
        for (int i = 0; i < 4 && i < a1_log.size(); i++) begin
            check_eq("wrap_a1_seq", 32'(a1_log[i]), 32'(a));
            a = a + 16'd1;
        end

        // Partial mask write then single-beat burst
        write_word(16'h0020, 8'hFF, 8'hFF);
        write_word(16'h0020, 8'h3C, 8'h0F);
        push_burst(16'h0020, 0);
        send_cmd(16'h0020, 16'd0);
        wait_done("len0_done");

        // Reset during ISSUE of a 16-beat burst
        for (int i = 8; i < 16; i++) write_word(16'(i), 8'(8'h80 + i), 8'hFF);
        rd_ready = 1'b0;
        push_burst(16'h0000, 15);
        send_cmd(16'h0000, 16'd15);
        repeat (3) @(posedge CLK);
        #1;
        check_eq("pre_rst_busy", 32'(busy), 1);
        RST = 1'b1;
        #1;
        check_eq("mid_rst_ctrl", 32'({wr_ready, rd_cmd_ready, rd_valid, rd_last, busy}), 0);
        check_eq("mid_rst_port0", 32'({CE0, WE0, A0, D0, WEM0}), 0);
        check_eq("mid_rst_port1", 32'({CE1, A1}), 0);
        exp_q.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        rd_ready = 1'b1;
        @(negedge CLK);
        check_eq("post_rst_cmd_ready", 32'(rd_cmd_ready), 1);
        check_eq("post_rst_rd_valid", 32'(rd_valid), 0);
        check_eq("post_rst_busy", 32'(busy), 0);
        push_burst(16'h0000, 7);
        send_cmd(16'h0000, 16'd7);
        wait_done("post_rst_burst_done");

        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
